// File: rtl/bank_arb_if.sv
// Bundles the requester-side and bank-side signals of one bank arbiter.
//   req_*   : per-requester request fields, packed requester i at [i*W +: W]
//   req_ack / req_err : one-cycle completion / abort pulses to the owner
//   rd_data : read data, valid only in the req_ack cycle of a read
//   bank_*  : the single shared bank port
// slave  : the arbiter's view (serves requests, drives the bank port)
// master : the environment's view (requesters plus the bank itself)
interface bank_arb_if #(
    parameter int REQ_N  = 4,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 4,
    parameter int DATA_W = 8
);
    logic [REQ_N-1:0]        req_valid;
    logic [REQ_N-1:0]        req_write;
    logic [REQ_N-1:0]        req_pad;
    logic [REQ_N*ROW_W-1:0]  req_row;
    logic [REQ_N*COL_W-1:0]  req_col;
    logic [REQ_N*DATA_W-1:0] req_wdata;
    logic [REQ_N-1:0]        req_ack;
    logic [REQ_N-1:0]        req_err;
    logic [DATA_W-1:0]       rd_data;

    logic                    bank_read_en;
    logic                    bank_write_en;
    logic                    bank_pad_en;
    logic [ROW_W-1:0]        bank_row;
    logic [COL_W-1:0]        bank_col;
    logic [DATA_W-1:0]       bank_wdata;
    logic [DATA_W-1:0]       bank_rdata;
    logic                    bank_ack;

    modport slave (
        input  req_valid, req_write, req_pad, req_row, req_col, req_wdata,
        input  bank_rdata, bank_ack,
        output req_ack, req_err, rd_data,
        output bank_read_en, bank_write_en, bank_pad_en,
        output bank_row, bank_col, bank_wdata
    );

    modport master (
        output req_valid, req_write, req_pad, req_row, req_col, req_wdata,
        output bank_rdata, bank_ack,
        input  req_ack, req_err, rd_data,
        input  bank_read_en, bank_write_en, bank_pad_en,
        input  bank_row, bank_col, bank_wdata
    );
endinterface

// File: rtl/bank_arb.sv
// Round-robin arbiter/sequencer sharing one row-buffered bank between
// REQ_N requesters. One request at a time is driven onto the bank port
// and held until bank_ack; a watchdog aborts after TIMEOUT busy cycles.
// Every transaction is followed by exactly one GAP cycle with the bank
// enables low so the bank can finish writeback.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : bank_arb_if.slave (requester fields, pulses, bank port)
//   grant_id : current owner (debug)
//   busy     : high in BUSY or GAP
module bank_arb #(
    parameter int REQ_N   = 4,
    parameter int ROW_W   = 8,
    parameter int COL_W   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64,
    localparam int GW     = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    bank_arb_if.slave     bus,
    output logic [GW-1:0] grant_id,
    output logic          busy
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic [GW-1:0] pick;
    logic          pick_found;
    logic [GW-1:0] next_ptr;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo REQ_N.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = rr_ptr_q;
        pick_found = 1'b0;
        for (int i = 0; i < REQ_N; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= REQ_N) idx = idx - REQ_N;
            if (!pick_found && bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick       = GW'(idx);
            end
        end
    end

    // Pointer moves past the owner so it goes to the back of the queue.
    assign next_ptr = (grant_q == GW'(REQ_N - 1)) ? '0 : grant_q + 1'b1;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        grant_d            = grant_q;
        wd_cnt_d           = wd_cnt_q;
        bus.req_ack        = '0;
        bus.req_err        = '0;
        bus.rd_data        = '0;
        bus.bank_read_en   = 1'b0;
        bus.bank_write_en  = 1'b0;
        bus.bank_pad_en    = 1'b0;
        bus.bank_row       = '0;
        bus.bank_col       = '0;
        bus.bank_wdata     = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d  = pick;
                    wd_cnt_d = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (!bus.req_valid[grant_q]) begin
                    // Owner withdrew mid-transaction: drop the bank port
                    // at once and abort without an ack.
                    bus.req_err[grant_q] = 1'b1;
                    rr_ptr_d             = next_ptr;
                    state_d              = GAP;
                end else begin
                    bus.bank_read_en  = !bus.req_write[grant_q];
                    bus.bank_write_en = bus.req_write[grant_q];
                    bus.bank_pad_en   = bus.req_pad[grant_q];
                    bus.bank_row      = bus.req_row[grant_q*ROW_W +: ROW_W];
                    bus.bank_col      = bus.req_col[grant_q*COL_W +: COL_W];
                    bus.bank_wdata    = bus.req_wdata[grant_q*DATA_W +: DATA_W];
                    if (bus.bank_ack) begin
                        // Ack wins over a coincident watchdog expiry.
                        bus.req_ack[grant_q] = 1'b1;
                        bus.rd_data          = bus.bank_rdata;
                        rr_ptr_d             = next_ptr;
                        state_d              = GAP;
                    end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
                        bus.req_err[grant_q] = 1'b1;
                        rr_ptr_d             = next_ptr;
                        state_d              = GAP;
                    end else if (wd_cnt_q != '1) begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
endmodule
